uart_line_arbiter: RTL and testbench

Shares one `uart_tx` transmitter between `NREQ` byte-stream requesters. Arbitration is round-robin and line-atomic: once a requester is granted, it keeps the UART until it sends a line feed (0x0A), so lines from different sources never interleave on the serial port. The block sits between the producers and the `uart_tx` strobe/ready interface, in the `clk_48` domain.

---
 rtl/uart_line_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_line_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_arbiter.sv
// Round-robin, line-atomic sharing of one uart_tx among NREQ byte streams; a grant is held until LF.
// Optional idle-grant watchdog compiled in with UART_ARB_TIMEOUT_EN (timeout_pulse tied 0 otherwise).
module uart_line_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 48000
) (
  input  logic              clk_48,
  input  logic              reset,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        uart_data,
  output logic              uart_strobe,
  input  logic              uart_ready,
  output logic              timeout_pulse
);

  localparam int LW = $clog2(NREQ);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t          r_state;
  logic [LW-1:0]   r_last;
  logic [LW-1:0]   r_owner;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_ready;
  logic [7:0]      r_data;
  logic            r_strobe;

  logic [LW-1:0]   w_pick_idx;
  logic            w_pick_vld;
  logic [7:0]      w_own_dat;
  logic            w_own_vld;
  logic            w_accept;

  // Scan downward so the nearest requester after r_last is the final (winning) assignment.
  always_comb begin
    w_pick_idx = '0;
    w_pick_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(r_last) + k) % NREQ]) begin
        w_pick_idx = LW'((int'(r_last) + k) % NREQ);
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_own_dat = req_data[{r_owner, 3'b000} +: 8];
  assign w_own_vld = req_valid[r_owner];
  // The strobe term blocks a second load before uart_tx has had a cycle to drop uart_ready.
  assign w_accept  = (r_state == S_LOCK) && w_own_vld && uart_ready && !r_strobe;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_tmo_pulse;
  logic          w_tmo_hit;
  assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT));
`endif

  always_ff @(posedge clk_48) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= LW'(NREQ - 1);
      r_owner  <= '0;
      r_grant  <= '0;
      r_ready  <= '0;
      r_data   <= 8'h00;
      r_strobe <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_tmo_pulse <= 1'b0;
`endif
    end else begin
      r_strobe <= 1'b0;
      r_ready  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_tmo_pulse <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
          if (w_pick_vld) begin
            r_grant             <= '0;
            r_grant[w_pick_idx] <= 1'b1;
            r_owner             <= w_pick_idx;
            r_state             <= S_LOCK;
          end
        end
        S_LOCK: begin
          if (w_accept) begin
            r_data           <= w_own_dat;
            r_strobe         <= 1'b1;
            r_ready[r_owner] <= 1'b1;
            if (w_own_dat == 8'h0A) begin
              r_grant <= '0;
              r_last  <= r_owner;
              r_state <= S_IDLE;
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          if (w_own_vld) begin
            r_tmo_cnt <= '0;
          end else if (w_tmo_hit) begin
            r_tmo_cnt   <= '0;
            r_tmo_pulse <= 1'b1;
            r_grant     <= '0;
            r_last      <= r_owner;
            r_state     <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign req_ready   = r_ready;
  assign uart_data   = r_data;
  assign uart_strobe = r_strobe;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_pulse = r_tmo_pulse;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Bench for uart_line_arbiter: round-robin table plus line-level scoreboard sequences.
// Timeout sequence follows whichever way UART_ARB_TIMEOUT_EN is set for the build.
module tb_uart_line_arbiter;

  localparam int NREQ = 4;

  logic              clk_48 = 1'b0;
  logic              reset;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [7:0]        uart_data;
  logic              uart_strobe;
  logic              uart_ready;
  logic              timeout_pulse;

  uart_line_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .clk_48       (clk_48),
    .reset        (reset),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .grant        (grant),
    .uart_data    (uart_data),
    .uart_strobe  (uart_strobe),
    .uart_ready   (uart_ready),
    .timeout_pulse(timeout_pulse)
  );

  always #10 clk_48 = ~clk_48;

  typedef struct {
    int         src;
    logic [7:0] b;
  } exp_t;

  typedef struct {
    int         pre;
    logic [3:0] mask;
    logic [3:0] exp_g;
  } rr_vec_t;

  int         checks = 0;
  int         errors = 0;
  int         strobe_cnt = 0;
  logic [7:0] rq[NREQ][$];
  exp_t       exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int r, input string s, input bit push);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      rq[r].push_back(s[i]);
      if (push) begin
        e.src = r;
        e.b   = s[i];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_48);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    uart_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || grant != '0) && n < 500) begin
      step();
      n++;
    end
    chk({nm, "_drained"}, 32'(exp_q.size()), 0);
    chk({nm, "_grant_idle"}, 32'(grant), 0);
  endtask

  // Requester model and output monitor, both on the falling edge.
  initial begin
    exp_t e;
    logic prev_strobe;
    prev_strobe = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    forever begin
      @(negedge clk_48);
      if (uart_strobe) begin
        strobe_cnt++;
        chk("strobe_gap", 32'(prev_strobe), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got byte %0h expected none", uart_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 32'(uart_data), 32'(e.b));
          chk("sb_ready", 32'(req_ready), 32'(1) << e.src);
        end
      end else if (req_ready != '0) begin
        chk("ready_wo_strobe", 32'(req_ready), 0);
      end
      prev_strobe = uart_strobe;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        req_valid[i] = (rq[i].size() > 0);
        req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
      end
    end
  end

  initial begin
    rr_vec_t tbl[9];
    int      c0;
    int      n;
    int      idle;
    bit      seen;

    tbl[0] = '{pre: -1, mask: 4'b0001, exp_g: 4'b0001};
    tbl[1] = '{pre: -1, mask: 4'b1010, exp_g: 4'b0010};
    tbl[2] = '{pre: -1, mask: 4'b1111, exp_g: 4'b0001};
    tbl[3] = '{pre:  0, mask: 4'b0001, exp_g: 4'b0001};
    tbl[4] = '{pre:  0, mask: 4'b1001, exp_g: 4'b1000};
    tbl[5] = '{pre:  1, mask: 4'b0011, exp_g: 4'b0001};
    tbl[6] = '{pre:  2, mask: 4'b0110, exp_g: 4'b0010};
    tbl[7] = '{pre:  3, mask: 4'b1100, exp_g: 4'b0100};
    tbl[8] = '{pre:  2, mask: 4'b1101, exp_g: 4'b1000};

    reset      = 1'b1;
    uart_ready = 1'b1;
    step();
    step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_strobe", 32'(uart_strobe), 0);
    chk("rst_data", 32'(uart_data), 0);
    chk("rst_timeout", 32'(timeout_pulse), 0);
    reset = 1'b0;

    // Single line "AB\n" from requester 1.
    load(1, "AB\n", 1'b1);
    step();
    chk("t1_grant", 32'(grant), 32'h2);
    wait_drain("t1");

    // Round-robin selection table; uart_ready low so nothing is consumed while checking.
    for (int t = 0; t < 9; t++) begin
      do_reset();
      if (tbl[t].pre >= 0) begin
        load(tbl[t].pre, "\n", 1'b1);
        wait_drain($sformatf("rr%0d_pre", t));
      end
      uart_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) if (tbl[t].mask[i]) load(i, "Z", 1'b0);
      repeat (3) step();
      chk($sformatf("rr%0d_grant", t), 32'(grant), 32'(tbl[t].exp_g));
    end

    // Two contenders alternate line by line: 0, 2, 0, 2.
    do_reset();
    load(0, "x\nx\n", 1'b0);
    load(2, "x\nx\n", 1'b0);
    load(0, "x\n", 1'b1);  // expectations only: rq[0] copy is trimmed below
    for (int k = 0; k < 2; k++) void'(rq[0].pop_back());
    begin
      exp_t e;
      e.src = 2; e.b = "x";   exp_q.push_back(e);
      e.src = 2; e.b = 8'h0A; exp_q.push_back(e);
      e.src = 0; e.b = "x";   exp_q.push_back(e);
      e.src = 0; e.b = 8'h0A; exp_q.push_back(e);
      e.src = 2; e.b = "x";   exp_q.push_back(e);
      e.src = 2; e.b = 8'h0A; exp_q.push_back(e);
    end
    wait_drain("t2");

    // Req 3 waits through req 0's whole line, then is granted one cycle after release.
    do_reset();
    load(0, "ABC\n", 1'b1);
    load(3, "ZZ\n", 1'b1);
    n = 0;
    do begin
      @(negedge clk_48);
      n++;
    end while (!(uart_strobe && uart_data == 8'h0A) && n < 200);
    chk("t3_lf_seen", 32'(n < 200), 1);
    chk("t3_release", 32'(grant), 0);
    @(negedge clk_48);
    chk("t3_regrant", 32'(grant), 32'h8);
    wait_drain("t3");

    // uart_ready stall mid-line, then two-cycle ready pulses: one byte per pulse.
    do_reset();
    c0 = strobe_cnt;
    load(0, "ABCDEF\n", 1'b1);
    n = 0;
    while (strobe_cnt - c0 < 2 && n < 100) begin
      step();
      n++;
    end
    uart_ready = 1'b0;
    c0 = strobe_cnt;
    repeat (20) step();
    chk("t4_stall", 32'(strobe_cnt - c0), 0);
    for (int p = 0; p < 4; p++) begin
      c0 = strobe_cnt;
      uart_ready = 1'b1;
      step();
      step();
      uart_ready = 1'b0;
      repeat (4) step();
      chk($sformatf("t4_pulse%0d", p), 32'(strobe_cnt - c0), 1);
    end
    uart_ready = 1'b1;
    wait_drain("t4");

    // Reset after two of four bytes; afterwards requester 0 wins over 3.
    do_reset();
    c0 = strobe_cnt;
    load(0, "AB", 1'b1);
    load(0, "C\n", 1'b0);
    n = 0;
    while (strobe_cnt - c0 < 2 && n < 100) begin
      step();
      n++;
    end
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    step();
    chk("t5_grant", 32'(grant), 0);
    chk("t5_ready", 32'(req_ready), 0);
    chk("t5_strobe", 32'(uart_strobe), 0);
    chk("t5_data", 32'(uart_data), 0);
    reset = 1'b0;
    load(3, "Q\n", 1'b0);
    load(0, "Q\n", 1'b1);
    begin
      exp_t e;
      e.src = 3; e.b = "Q";   exp_q.push_back(e);
      e.src = 3; e.b = 8'h0A; exp_q.push_back(e);
    end
    step();
    chk("t5_first", 32'(grant), 32'h1);
    wait_drain("t5");

    // Requester 2 stalls mid-line while requester 1 waits.
    do_reset();
    load(2, "AB", 1'b1);
    n = 0;
    while (grant != 4'b0100 && n < 50) begin
      step();
      n++;
    end
    chk("t6_owner", 32'(grant), 32'h4);
`ifdef UART_ARB_TIMEOUT_EN
    load(1, "M\n", 1'b1);
    idle = 0;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 200) begin
      step();
      n++;
      if (timeout_pulse) seen = 1'b1;
      else if (grant == 4'b0100 && !req_valid[2]) idle++;
    end
    chk("t6_pulse", 32'(seen), 1);
    chk("t6_idle_cycles", 32'(idle), 16);
    chk("t6_released", 32'(grant), 0);
    step();
    chk("t6_pulse_width", 32'(timeout_pulse), 0);
    chk("t6_next_owner", 32'(grant), 32'h2);
    wait_drain("t6");
`else
    load(1, "M\n", 1'b0);
    seen = 1'b0;
    repeat (1100) begin
      step();
      if (timeout_pulse) seen = 1'b1;
    end
    chk("t6_no_pulse", 32'(seen), 0);
    chk("t6_held", 32'(grant), 32'h4);
    chk("t6_sent_two", 32'(exp_q.size()), 0);
    do_reset();
`endif

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
